// File: rtl/pll_frac_cen.sv
`timescale 1ns/1ps
// pll_frac_cen: multi-channel fractional clock-enable synthesiser.
// Each channel adds its increment into a phase accumulator every refclk edge
// and emits a one-cycle enable on every accumulator wrap. New increments are
// staged in a shadow register and only take effect at a wrap, so a retune
// never produces a runt or stretched period. A settle counter drives a lock
// indicator that stays low while any retune is outstanding or recent.
module pll_frac_cen #(
  parameter int          CHANNELS    = 2,
  parameter int          ACC_W       = 32,
  parameter logic [31:0] INIT_INC    = 32'h0800_0000,
  parameter int          LOCK_CYCLES = 16,
  localparam int         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                inc_wr,
  input  logic [CH_W-1:0]     inc_ch,
  input  logic [ACC_W-1:0]    inc_val,
  output logic                inc_ready,
  output logic [CHANNELS-1:0] cen,
  output logic                locked
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

  logic [ACC_W-1:0]    acc_q    [CHANNELS];
  logic [ACC_W-1:0]    acc_d    [CHANNELS];
  logic [ACC_W-1:0]    inc_q    [CHANNELS];
  logic [ACC_W-1:0]    inc_d    [CHANNELS];
  logic [ACC_W-1:0]    shadow_q [CHANNELS];
  logic [ACC_W-1:0]    shadow_d [CHANNELS];
  logic [ACC_W:0]      sumWide  [CHANNELS];
  logic [CHANNELS-1:0] pending_q;
  logic [CHANNELS-1:0] pending_d;
  logic [CHANNELS-1:0] cen_q;
  logic [CHANNELS-1:0] cen_d;
  logic [CHANNELS-1:0] carry;
  logic [CHANNELS-1:0] applyNow;
  logic [CHANNELS-1:0] writeHit;
  logic [7:0]          cnt_q;
  logic [7:0]          cnt_d;
  logic                locked_q;
  logic                locked_d;
  logic                chInRange;

  // Host handshake: channels that do not exist always look ready so a stray write cannot stall the host.
  always_comb begin
    chInRange = ({1'b0, inc_ch} < CH_LIMIT);
    inc_ready = 1'b1;
    if (chInRange) begin
      inc_ready = !pending_q[inc_ch];
    end
  end

  // Phase accumulation; a staged increment is adopted at a wrap, or immediately if the channel is stopped.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sumWide[c]  = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
      carry[c]    = sumWide[c][ACC_W];
      acc_d[c]    = sumWide[c][ACC_W-1:0];
      cen_d[c]    = carry[c];
      applyNow[c] = pending_q[c] & (carry[c] | (inc_q[c] == '0));
      inc_d[c]    = applyNow[c] ? shadow_q[c] : inc_q[c];
    end
  end

  // Write capture into the shadow register; a channel with a staged value ignores further writes.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      writeHit[c]  = inc_wr & chInRange & (inc_ch == CH_W'(c)) & ~pending_q[c];
      shadow_d[c]  = writeHit[c] ? inc_val : shadow_q[c];
      pending_d[c] = writeHit[c] | (pending_q[c] & ~applyNow[c]);
    end
  end

  // Settle counter restarts on any apply; lock needs an expired counter and no staged writes.
  always_comb begin
    cnt_d = cnt_q;
    if (|applyNow) begin
      cnt_d = 8'(LOCK_CYCLES);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
    locked_d = (cnt_d == 8'd0) && (pending_d == '0);
  end

  // State registers with synchronous reset taking priority over everything else.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]    <= '0;
        inc_q[c]    <= INIT_INC[ACC_W-1:0];
        shadow_q[c] <= '0;
      end
      pending_q <= '0;
      cen_q     <= '0;
      cnt_q     <= 8'(LOCK_CYCLES);
      locked_q  <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]    <= acc_d[c];
        inc_q[c]    <= inc_d[c];
        shadow_q[c] <= shadow_d[c];
      end
      pending_q <= pending_d;
      cen_q     <= cen_d;
      cnt_q     <= cnt_d;
      locked_q  <= locked_d;
    end
  end

  assign cen    = cen_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_pll_frac_cen.sv
`timescale 1ns/1ps
// tb_pll_frac_cen: directed retune scenarios with a pulse scoreboard.
// Expected enable edges (relative to reset release) are queued per channel
// when each scenario is issued; the monitor pops them as pulses appear.
module tb_pll_frac_cen;

  localparam int CHANNELS = 3;
  localparam int ACC_W    = 32;

  logic                refclk = 1'b0;
  logic                rst    = 1'b1;
  logic                inc_wr = 1'b0;
  logic [1:0]          inc_ch = 2'd0;
  logic [ACC_W-1:0]    inc_val = '0;
  logic                inc_ready;
  logic [CHANNELS-1:0] cen;
  logic                locked;

  int cyc = 0;
  int base = 3;
  int errors = 0;
  int checks = 0;
  int expQ [CHANNELS][$];
  int pulseCnt [CHANNELS];
  int winStart;

  pll_frac_cen #(
    .CHANNELS   (CHANNELS),
    .ACC_W      (ACC_W),
    .INIT_INC   (32'h0800_0000),
    .LOCK_CYCLES(16)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .inc_wr   (inc_wr),
    .inc_ch   (inc_ch),
    .inc_val  (inc_val),
    .inc_ready(inc_ready),
    .cen      (cen),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  // Edge counter; at any point after an edge it equals the number of edges so far.
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d (edge %0d)", name, actual, expected, cyc - base);
    end
  endtask

  task automatic waitEdge(input int n);
    while (cyc < base + n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic pushRange(input int c, input int first, input int step, input int last);
    for (int t = first; t <= last; t += step) expQ[c].push_back(base + t);
  endtask

  // Drives a write so that it is sampled on edge w.
  task automatic applyStimulus(input int w, input logic [1:0] ch, input logic [31:0] val);
    waitEdge(w - 1);
    inc_wr  = 1'b1;
    inc_ch  = ch;
    inc_val = val;
    waitEdge(w);
    inc_wr  = 1'b0;
  endtask

  // Scoreboard monitor: every pulse must match the head of its channel's queue; overdue entries are misses.
  always @(negedge refclk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      while (expQ[c].size() > 0 && expQ[c][0] < cyc) begin
        checkOutput($sformatf("missedPulse ch%0d", c), 32'(cyc - base), 32'(expQ[c][0] - base));
        void'(expQ[c].pop_front());
      end
      if (cen[c] === 1'b1) begin
        pulseCnt[c]++;
        if (expQ[c].size() > 0) begin
          checkOutput($sformatf("pulseEdge ch%0d", c), 32'(cyc - base), 32'(expQ[c][0] - base));
          if (expQ[c][0] == cyc) void'(expQ[c].pop_front());
        end else begin
          checkOutput($sformatf("unexpectedPulse ch%0d", c), 32'(cyc - base), 32'hFFFF_FFFF);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, want finish before 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int c = 0; c < CHANNELS; c++) pulseCnt[c] = 0;

    // Reset and the default refclk/32 rate on every channel.
    waitEdge(0);
    rst = 1'b0;
    checkOutput("resetCen", 32'(cen), 32'd0);
    checkOutput("resetLocked", 32'(locked), 32'd0);
    checkOutput("resetReady", 32'(inc_ready), 32'd1);
    pushRange(0, 32, 32, 3328);
    pushRange(1, 32, 32, 288);
    pushRange(2, 32, 32, 3584);
    waitEdge(15);
    checkOutput("lockedEarly", 32'(locked), 32'd0);
    waitEdge(16);
    checkOutput("lockedRise", 32'(locked), 32'd1);
    waitEdge(256);
    checkOutput("lockedHold", 32'(locked), 32'd1);

    // Half-rate retune on ch1 mid-period: old period completes at 288.
    applyStimulus(270, 2'd1, 32'h8000_0000);
    pushRange(1, 290, 2, 312);
    checkOutput("ch1ReadyPending", 32'(inc_ready), 32'd0);
    checkOutput("lockedDropOnWrite", 32'(locked), 32'd0);
    waitEdge(287);
    checkOutput("ch1ReadyBeforeApply", 32'(inc_ready), 32'd0);
    waitEdge(288);
    checkOutput("ch1ReadyAfterApply", 32'(inc_ready), 32'd1);
    waitEdge(303);
    checkOutput("lockedSettling", 32'(locked), 32'd0);
    waitEdge(304);
    checkOutput("lockedResettled", 32'(locked), 32'd1);

    // One-third rate on ch1, applied at the 312 pulse.
    applyStimulus(311, 2'd1, 32'h5555_5555);
    pushRange(1, 316, 3, 3502);
    waitEdge(313);
    winStart = pulseCnt[1];

    // Stop ch0 at its next wrap (3328).
    applyStimulus(3310, 2'd0, 32'h0000_0000);
    checkOutput("ch0ReadyStopPending", 32'(inc_ready), 32'd0);
    waitEdge(3313);
    checkOutput("ch1ThirdRateCount", 32'(pulseCnt[1] - winStart), 32'd999);
    waitEdge(3327);
    checkOutput("ch0ReadyBeforeStop", 32'(inc_ready), 32'd0);
    waitEdge(3328);
    checkOutput("ch0ReadyAfterStop", 32'(inc_ready), 32'd1);
    checkOutput("lockedAfterStop", 32'(locked), 32'd0);
    waitEdge(3329);
    winStart = pulseCnt[0];

    // Restart the stopped ch0 at refclk/16: apply on the very next edge.
    applyStimulus(3400, 2'd0, 32'h1000_0000);
    checkOutput("ch0StoppedPulses", 32'(pulseCnt[0] - winStart), 32'd0);
    checkOutput("ch0ReadyRestart", 32'(inc_ready), 32'd0);
    waitEdge(3401);
    checkOutput("ch0ReadyImmediateApply", 32'(inc_ready), 32'd1);
    pushRange(0, 3417, 16, 3593);

    // Second write while pending is dropped; only refclk/4 is applied at 3502.
    applyStimulus(3500, 2'd1, 32'h4000_0000);
    checkOutput("ch1ReadyFirstWrite", 32'(inc_ready), 32'd0);
    applyStimulus(3501, 2'd1, 32'h2000_0000);
    checkOutput("ch1ReadyDroppedWrite", 32'(inc_ready), 32'd0);
    waitEdge(3502);
    checkOutput("ch1ReadyAfterDrop", 32'(inc_ready), 32'd1);
    pushRange(1, 3505, 4, 3597);

    // Out-of-range channel write has no effect.
    waitEdge(3550);
    checkOutput("lockedBeforeBadCh", 32'(locked), 32'd1);
    applyStimulus(3551, 2'd3, 32'h0000_0000);
    checkOutput("badChReady", 32'(inc_ready), 32'd1);
    waitEdge(3552);
    checkOutput("lockedAfterBadCh", 32'(locked), 32'd1);

    // Reset mid-period with a ch1 write pending.
    applyStimulus(3600, 2'd1, 32'h8000_0000);
    checkOutput("ch1ReadyBeforeReset", 32'(inc_ready), 32'd0);
    rst = 1'b1;
    waitEdge(3601);
    rst = 1'b0;
    checkOutput("midResetCen", 32'(cen), 32'd0);
    checkOutput("midResetLocked", 32'(locked), 32'd0);
    checkOutput("midResetReady", 32'(inc_ready), 32'd1);
    for (int c = 0; c < CHANNELS; c++) pushRange(c, 3633, 32, 3697);
    waitEdge(3616);
    checkOutput("lockedAfterResetEarly", 32'(locked), 32'd0);
    waitEdge(3617);
    checkOutput("lockedAfterResetRise", 32'(locked), 32'd1);
    waitEdge(3700);
    for (int c = 0; c < CHANNELS; c++) begin
      checkOutput($sformatf("leftoverPulses ch%0d", c), 32'(expQ[c].size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
